// File: rtl/riskv_mem.sv
// riskv_mem: dual-port RAM for the RV32I core with per-port latency modelled by busy stalls.
// Each port has an IDLE/BUSY timer; array access and byte-lane writes happen at the accepting edge.

module riskv_mem_port #(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_req,
    output logic o_acc,
    output logic o_busy
);
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0] START = CW'(LAT - 1);

    typedef enum logic {IDLE, BUSY} state_t;
    state_t r_state, w_state_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // Requests arriving while BUSY are dropped, not queued.
    always_comb begin
        o_acc      = i_rst_n && i_req && r_state == IDLE;
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        if (r_state == BUSY) begin
            w_cnt_nx = r_cnt - CW'(1);
            if (r_cnt == CW'(1)) w_state_nx = IDLE;
        end else if (o_acc && LAT > 1) begin
            w_state_nx = BUSY;
            w_cnt_nx   = START;
        end
    end

    assign o_busy = r_state == BUSY;
endmodule

module riskv_mem #(
    parameter int    ADDR_WIDTH = 12,
    parameter int    I_LATENCY  = 1,
    parameter int    D_LATENCY  = 1,
    parameter string INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_i_addr,
    input  logic        mem_i_rstrb,
    output logic [31:0] mem_i_rdata,
    output logic        mem_i_rbusy,
    input  logic [31:0] mem_d_addr,
    input  logic [31:0] mem_d_wdata,
    input  logic [3:0]  mem_d_wmask,
    input  logic        mem_d_wstrb,
    input  logic        mem_d_rstrb,
    output logic [31:0] mem_d_rdata,
    output logic        mem_d_rbusy,
    output logic        mem_d_wbusy
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_i_rdata, r_d_rdata;
    logic        r_d_wr;
    logic [ADDR_WIDTH-1:0] w_i_idx, w_d_idx;
    logic w_i_acc, w_i_busy, w_d_acc, w_d_busy, w_d_wr, w_d_rd, w_unused;

    assign w_i_idx  = mem_i_addr[ADDR_WIDTH+1:2];
    assign w_d_idx  = mem_d_addr[ADDR_WIDTH+1:2];
    assign w_unused = ^{mem_i_addr[31:ADDR_WIDTH+2], mem_i_addr[1:0],
                        mem_d_addr[31:ADDR_WIDTH+2], mem_d_addr[1:0]};

    riskv_mem_port #(.LAT(I_LATENCY)) u_i_port (
        .clk    (clk),
        .i_rst_n(rst),
        .i_req  (mem_i_rstrb),
        .o_acc  (w_i_acc),
        .o_busy (w_i_busy)
    );

    riskv_mem_port #(.LAT(D_LATENCY)) u_d_port (
        .clk    (clk),
        .i_rst_n(rst),
        .i_req  (mem_d_wstrb | mem_d_rstrb),
        .o_acc  (w_d_acc),
        .o_busy (w_d_busy)
    );

    // A store wins over a simultaneous load on the data port.
    assign w_d_wr = w_d_acc & mem_d_wstrb;
    assign w_d_rd = w_d_acc & ~mem_d_wstrb;

    always_ff @(posedge clk) begin
        if (w_d_wr)
            for (int b = 0; b < 4; b++)
                if (mem_d_wmask[b]) r_mem[w_d_idx][8*b +: 8] <= mem_d_wdata[8*b +: 8];
    end

    // Hold registers sample the array before this edge's write lands (read-before-write).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_i_rdata <= '0;
            r_d_rdata <= '0;
            r_d_wr    <= 1'b0;
        end else begin
            if (w_i_acc) r_i_rdata <= r_mem[w_i_idx];
            if (w_d_rd) r_d_rdata <= r_mem[w_d_idx];
            if (w_d_acc) r_d_wr <= mem_d_wstrb;
        end
    end

    assign mem_i_rdata = r_i_rdata;
    assign mem_d_rdata = r_d_rdata;
    assign mem_i_rbusy = w_i_busy;
    assign mem_d_rbusy = w_d_busy & ~r_d_wr;
    assign mem_d_wbusy = w_d_busy & r_d_wr;
endmodule

// File: tb/tb_riskv_mem.sv
// tb_riskv_mem: two instances (latencies 1/1 and 4/3) share one stimulus stream and are
// checked every cycle against a remaining-cycles memory model plus directed literal checks.
module tb_riskv_mem;
    logic clk, rst;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_wmask;
    logic        i_rstrb, d_wstrb, d_rstrb;
    logic [1:0][31:0] i_rd, d_rd;
    logic [1:0] ib, drb, dwb;

    int n_chk = 0, n_fail = 0;
    bit chk_on = 0;

    logic [31:0] m_mem [2][4096];
    logic [31:0] m_ird [2], m_drd [2];
    int  m_ib [2], m_db [2];
    bit  m_dw [2];
    int  lat_i [2] = '{1, 4};
    int  lat_d [2] = '{1, 3};

    riskv_mem #(.ADDR_WIDTH(12), .I_LATENCY(1), .D_LATENCY(1)) u0 (
        .clk(clk), .rst(rst),
        .mem_i_addr(i_addr), .mem_i_rstrb(i_rstrb), .mem_i_rdata(i_rd[0]), .mem_i_rbusy(ib[0]),
        .mem_d_addr(d_addr), .mem_d_wdata(d_wdata), .mem_d_wmask(d_wmask),
        .mem_d_wstrb(d_wstrb), .mem_d_rstrb(d_rstrb), .mem_d_rdata(d_rd[0]),
        .mem_d_rbusy(drb[0]), .mem_d_wbusy(dwb[0])
    );

    riskv_mem #(.ADDR_WIDTH(12), .I_LATENCY(4), .D_LATENCY(3)) u1 (
        .clk(clk), .rst(rst),
        .mem_i_addr(i_addr), .mem_i_rstrb(i_rstrb), .mem_i_rdata(i_rd[1]), .mem_i_rbusy(ib[1]),
        .mem_d_addr(d_addr), .mem_d_wdata(d_wdata), .mem_d_wmask(d_wmask),
        .mem_d_wstrb(d_wstrb), .mem_d_rstrb(d_rstrb), .mem_d_rdata(d_rd[1]),
        .mem_d_rbusy(drb[1]), .mem_d_wbusy(dwb[1])
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s u%0d got=%h exp=%h at %0t", nm, k, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ird[k] = 0; m_drd[k] = 0; m_ib[k] = 0; m_db[k] = 0; m_dw[k] = 0;
        end
    endtask

    // Advances the model across the next rising edge using the inputs currently driven.
    task automatic model_step();
        int ii, di;
        if (!rst) begin
            model_reset();
            return;
        end
        ii = int'(i_addr[13:2]);
        di = int'(d_addr[13:2]);
        for (int k = 0; k < 2; k++) begin
            if (m_ib[k] > 0) m_ib[k]--;
            else if (i_rstrb) begin
                m_ird[k] = m_mem[k][ii];
                m_ib[k] = lat_i[k] - 1;
            end
            if (m_db[k] > 0) m_db[k]--;
            else if (d_wstrb || d_rstrb) begin
                m_dw[k] = d_wstrb;
                m_db[k] = lat_d[k] - 1;
                if (d_wstrb) begin
                    for (int b = 0; b < 4; b++)
                        if (d_wmask[b]) m_mem[k][di][8*b +: 8] = d_wdata[8*b +: 8];
                end else m_drd[k] = m_mem[k][di];
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_on)
            for (int k = 0; k < 2; k++) begin
                check("i_rdata", k, i_rd[k], m_ird[k]);
                check("d_rdata", k, d_rd[k], m_drd[k]);
                check("i_rbusy", k, 32'(ib[k]), 32'(m_ib[k] > 0));
                check("d_rbusy", k, 32'(drb[k]), 32'(m_db[k] > 0 && !m_dw[k]));
                check("d_wbusy", k, 32'(dwb[k]), 32'(m_db[k] > 0 && m_dw[k]));
            end
    end

    task automatic cyc();
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic dwrite(input logic [31:0] a, input logic [31:0] dat, input logic [3:0] m);
        d_addr = a; d_wdata = dat; d_wmask = m; d_wstrb = 1; d_rstrb = 0;
        cyc();
        d_wstrb = 0;
        cyc(); cyc();
    endtask

    task automatic dread(input logic [31:0] a);
        d_addr = a; d_rstrb = 1;
        cyc();
        d_rstrb = 0;
        cyc(); cyc();
    endtask

    task automatic iread(input logic [31:0] a);
        i_addr = a; i_rstrb = 1;
        cyc();
        i_rstrb = 0;
        cyc(); cyc(); cyc();
    endtask

    task automatic async_reset_zero_check();
        #2 rst = 0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rst_i_rdata", k, i_rd[k], 32'h0);
            check("rst_d_rdata", k, d_rd[k], 32'h0);
            check("rst_i_rbusy", k, 32'(ib[k]), 32'h0);
            check("rst_d_rbusy", k, 32'(drb[k]), 32'h0);
            check("rst_d_wbusy", k, 32'(dwb[k]), 32'h0);
        end
        model_reset();
        rst = 1;
    endtask

    function automatic logic [31:0] pre(input int w);
        case (w)
            0:  return 32'h0000_0013;
            4:  return 32'hDEAD_BEEF;
            8:  return 32'h1122_3344;
            16: return 32'h0000_0000;
            default: return 32'hA500_0000 | 32'(w * 32'h0101);
        endcase
    endfunction

    initial begin
        logic [31:0] r;
        rst = 1; i_addr = 0; d_addr = 0; d_wdata = 0; d_wmask = 0;
        i_rstrb = 0; d_wstrb = 0; d_rstrb = 0;
        model_reset();
        #2 rst = 0;
        chk_on = 1;
        @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check("init_i_rdata", k, i_rd[k], 32'h0);
            check("init_d_wbusy", k, 32'(dwb[k]), 32'h0);
        end
        rst = 1;

        for (int w = 0; w < 32; w++) dwrite(32'(w * 4), pre(w), 4'hF);

        iread(0);
        dread(32'h10);
        async_reset_zero_check();
        i_addr = 0; i_rstrb = 1;
        cyc();
        i_rstrb = 0;
        check("boot_fetch", 0, i_rd[0], 32'h0000_0013);
        check("boot_fetch", 1, i_rd[1], 32'h0000_0013);
        check("boot_busy", 0, 32'(ib[0]), 32'h0);
        check("boot_busy", 1, 32'(ib[1]), 32'h1);
        cyc(); cyc(); cyc();

        d_addr = 32'h10; d_rstrb = 1;
        cyc();
        check("lat3_t1_busy", 1, 32'(drb[1]), 32'h1);
        check("lat3_t1_data", 1, d_rd[1], 32'hDEAD_BEEF);
        check("lat1_t1_data", 0, d_rd[0], 32'hDEAD_BEEF);
        d_addr = 32'h20;
        cyc();
        check("lat3_t2_busy", 1, 32'(drb[1]), 32'h1);
        check("lat3_ignored", 1, d_rd[1], 32'hDEAD_BEEF);
        check("lat1_b2b", 0, d_rd[0], 32'h1122_3344);
        d_rstrb = 0;
        cyc();
        check("lat3_t3_busy", 1, 32'(drb[1]), 32'h0);
        check("lat3_t3_data", 1, d_rd[1], 32'hDEAD_BEEF);
        cyc();

        dwrite(32'h20, 32'hAAAA_AAAA, 4'b0100);
        dread(32'h20);
        for (int k = 0; k < 2; k++) check("byte_lane2", k, d_rd[k], 32'h11AA_3344);
        dwrite(32'h20, 32'h5566_5566, 4'b0011);
        dread(32'h20);
        for (int k = 0; k < 2; k++) check("half_low", k, d_rd[k], 32'h11AA_5566);
        dwrite(32'h20, 32'hFFFF_FFFF, 4'b0000);
        dread(32'h20);
        for (int k = 0; k < 2; k++) check("mask_zero", k, d_rd[k], 32'h11AA_5566);

        i_addr = 32'h40; i_rstrb = 1;
        d_addr = 32'h40; d_wdata = 32'hCAFE_F00D; d_wmask = 4'hF; d_wstrb = 1;
        cyc();
        i_rstrb = 0; d_wstrb = 0;
        for (int k = 0; k < 2; k++) check("rbw_old", k, i_rd[k], 32'h0);
        cyc(); cyc(); cyc();
        iread(32'h40);
        for (int k = 0; k < 2; k++) check("rbw_new", k, i_rd[k], 32'hCAFE_F00D);

        dwrite(32'h4004, 32'h1234_5678, 4'hF);
        dread(32'h0004);
        for (int k = 0; k < 2; k++) check("wrap", k, d_rd[k], 32'h1234_5678);
        d_addr = 32'h8; d_wdata = 32'h0BAD_CAFE; d_wmask = 4'hF; d_wstrb = 1; d_rstrb = 1;
        cyc();
        d_wstrb = 0; d_rstrb = 0;
        check("prio_wbusy", 1, 32'(dwb[1]), 32'h1);
        check("prio_rbusy", 1, 32'(drb[1]), 32'h0);
        for (int k = 0; k < 2; k++) check("prio_rdata", k, d_rd[k], 32'h1234_5678);
        cyc(); cyc();
        dread(32'h8);
        for (int k = 0; k < 2; k++) check("prio_written", k, d_rd[k], 32'h0BAD_CAFE);

        i_addr = 0; i_rstrb = 1;
        cyc();
        i_rstrb = 0;
        cyc();
        check("midbusy_pre", 1, 32'(ib[1]), 32'h1);
        async_reset_zero_check();
        i_addr = 32'h10; i_rstrb = 1;
        cyc();
        i_rstrb = 0;
        check("fresh_t1_busy", 1, 32'(ib[1]), 32'h1);
        check("fresh_data", 1, i_rd[1], 32'hDEAD_BEEF);
        cyc();
        check("fresh_t2_busy", 1, 32'(ib[1]), 32'h1);
        cyc();
        check("fresh_t3_busy", 1, 32'(ib[1]), 32'h1);
        cyc();
        check("fresh_t4_busy", 1, 32'(ib[1]), 32'h0);

        for (int n = 0; n < 800; n++) begin
            r = $urandom();
            i_addr = (r & 32'hFFFF_C000) | 32'($urandom_range(0, 31) << 2) | ($urandom() & 32'h3);
            r = $urandom();
            d_addr = (r & 32'hFFFF_C000) | 32'($urandom_range(0, 31) << 2) | ($urandom() & 32'h3);
            d_wdata = $urandom();
            d_wmask = 4'($urandom());
            i_rstrb = $urandom_range(0, 2) != 0;
            d_wstrb = $urandom_range(0, 3) == 0;
            d_rstrb = $urandom_range(0, 2) == 0;
            cyc();
        end
        i_rstrb = 0; d_wstrb = 0; d_rstrb = 0;
        cyc(); cyc(); cyc(); cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
